// File: rtl/ddr2pe_bbuf_if.sv
// DDR-to-bbuf unpacker bus: control/config, inbound DDR stream, bbuf write port.
interface ddr2pe_bbuf_if #(
  parameter int DDR_W  = 64,
  parameter int DATA_W = 16,
  parameter int TAIL_W = 8,
  parameter int ADDR_W = 8,
  parameter int RES_W  = DATA_W + TAIL_W
);
  logic              start;
  logic              done;
  logic [1:0]        conf_trans_type;
  logic [7:0]        conf_trans_num;
  logic [ADDR_W-1:0] conf_addr_base;
  logic [DDR_W-1:0]  ddr1_data;
  logic              ddr1_valid;
  logic              ddr1_ready;
  logic              bbuf_wr_en;
  logic [ADDR_W-1:0] bbuf_wr_addr;
  logic [RES_W-1:0]  bbuf_wr_data;
  logic [1:0]        bbuf_wr_mask;

  // Controller / DDR source side.
  modport master (
    output start, conf_trans_type, conf_trans_num, conf_addr_base, ddr1_data, ddr1_valid,
    input  done, ddr1_ready, bbuf_wr_en, bbuf_wr_addr, bbuf_wr_data, bbuf_wr_mask
  );

  // Unpacker side.
  modport slave (
    input  start, conf_trans_type, conf_trans_num, conf_addr_base, ddr1_data, ddr1_valid,
    output done, ddr1_ready, bbuf_wr_en, bbuf_wr_addr, bbuf_wr_data, bbuf_wr_mask
  );
endinterface

// File: rtl/ddr2pe_bbuf.sv
// Unpacks inbound DDR words into per-entry bias-buffer writes (data or tail field).
module ddr2pe_bbuf #(
  parameter int DDR_W     = 64,
  parameter int DATA_W    = 16,
  parameter int TAIL_W    = 8,
  parameter int BUF_DEPTH = 256,
  parameter int ADDR_W    = $clog2(BUF_DEPTH),
  parameter int RES_W     = DATA_W + TAIL_W
) (
  input logic         clk,
  input logic         rst,
  ddr2pe_bbuf_if.slave bus
);
  localparam int DPACK  = DDR_W / DATA_W;
  localparam int TPACK  = DDR_W / TAIL_W;
  localparam int DIDX_W = $clog2(DPACK);
  localparam int TIDX_W = $clog2(TPACK);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_FIN} state_t;

  state_t            r_state, w_next;
  logic              r_tail;
  logic [7:0]        r_words_left;
  logic [7:0]        r_elem_left;
  logic [ADDR_W-1:0] r_addr;
  logic [DDR_W-1:0]  r_word;
  logic              r_word_vld;
  logic [5:0]        r_slice_cnt;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [RES_W-1:0]  r_wr_data;
  logic [1:0]        r_wr_mask;

  logic [5:0]        w_pack_m1;
  logic              w_slice_last, w_ready, w_accept, w_emit;
  logic [8:0]        w_num9;
  logic [7:0]        w_words_init;
  logic [DPACK-1:0][DATA_W-1:0] w_dsl;
  logic [TPACK-1:0][TAIL_W-1:0] w_tsl;
  logic [DATA_W-1:0] w_dslice;
  logic [TAIL_W-1:0] w_tslice;

  assign w_pack_m1    = r_tail ? 6'(TPACK-1) : 6'(DPACK-1);
  assign w_slice_last = (r_slice_cnt == w_pack_m1);
  // Ready looks only at registers: empty holder, or the last slice is leaving this cycle.
  assign w_ready  = (r_state == S_RECV) && (r_words_left != 8'd0) &&
                    (!r_word_vld || (w_slice_last && r_elem_left != 8'd0));
  assign w_accept = bus.ddr1_valid && w_ready;
  assign w_emit   = (r_state == S_RECV) && r_word_vld && (r_elem_left != 8'd0);

  assign w_dsl    = r_word;
  assign w_tsl    = r_word;
  assign w_dslice = w_dsl[r_slice_cnt[DIDX_W-1:0]];
  assign w_tslice = w_tsl[r_slice_cnt[TIDX_W-1:0]];

  assign w_num9       = {1'b0, bus.conf_trans_num};
  assign w_words_init = bus.conf_trans_type[0] ? 8'((w_num9 + 9'(TPACK-1)) / 9'(TPACK))
                                               : 8'((w_num9 + 9'(DPACK-1)) / 9'(DPACK));

  assign bus.ddr1_ready   = w_ready;
  assign bus.done         = (r_state == S_FIN);
  assign bus.bbuf_wr_en   = r_wr_en;
  assign bus.bbuf_wr_addr = r_wr_addr;
  assign bus.bbuf_wr_data = r_wr_data;
  assign bus.bbuf_wr_mask = r_wr_mask;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state: FIN is entered once the final entry's write is on the port.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start)
                w_next = (bus.conf_trans_type[1] && bus.conf_trans_num != 8'd0) ? S_RECV : S_FIN;
      S_RECV: if (r_elem_left == 8'd0) w_next = S_FIN;
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Config latch, word holder, slice unpacking and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tail       <= 1'b0;
      r_words_left <= '0;
      r_elem_left  <= '0;
      r_addr       <= '0;
      r_word       <= '0;
      r_word_vld   <= 1'b0;
      r_slice_cnt  <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wr_mask    <= '0;
    end else begin
      r_wr_en <= w_emit;
      if (r_state == S_IDLE && bus.start) begin
        r_tail       <= bus.conf_trans_type[0];
        r_words_left <= w_words_init;
        r_elem_left  <= bus.conf_trans_num;
        r_addr       <= bus.conf_addr_base;
        r_word_vld   <= 1'b0;
        r_slice_cnt  <= '0;
      end
      if (w_emit) begin
        r_wr_addr   <= r_addr;
        r_wr_data   <= r_tail ? {{DATA_W{1'b0}}, w_tslice} : {w_dslice, {TAIL_W{1'b0}}};
        r_wr_mask   <= r_tail ? 2'b01 : 2'b10;
        r_addr      <= (r_addr == ADDR_W'(BUF_DEPTH-1)) ? '0 : r_addr + 1'b1;
        r_elem_left <= r_elem_left - 8'd1;
        r_slice_cnt <= r_slice_cnt + 6'd1;
        // Last slice of the word, or last entry of the pass (rest of word dropped).
        if (w_slice_last || r_elem_left == 8'd1) r_word_vld <= 1'b0;
      end
      // A new word overrides the clear above when it lands on the last-slice cycle.
      if (w_accept) begin
        r_word       <= bus.ddr1_data;
        r_word_vld   <= 1'b1;
        r_slice_cnt  <= '0;
        r_words_left <= r_words_left - 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_ddr2pe_bbuf.sv
// Directed + randomized bench for ddr2pe_bbuf against a per-entry reference model.
module tb_ddr2pe_bbuf;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ddr2pe_bbuf_if bif ();
  ddr2pe_bbuf dut (.clk(clk), .rst(rst), .bus(bif));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int          obs_addr[$];
  logic [23:0] obs_data[$];
  logic [1:0]  obs_mask[$];
  int          obs_cyc[$];
  int          acc_cyc[$];
  logic [63:0] words[$];

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: collect writes, done pulses and word accepts away from the active edge.
  always @(negedge clk) begin
    if (bif.bbuf_wr_en) begin
      obs_addr.push_back(int'(bif.bbuf_wr_addr));
      obs_data.push_back(bif.bbuf_wr_data);
      obs_mask.push_back(bif.bbuf_wr_mask);
      obs_cyc.push_back(cyc);
    end
    if (bif.done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (bif.ddr1_valid && bif.ddr1_ready) acc_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back({$urandom, $urandom});
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".done"},  64'(bif.done), 0);
    chk({tag, ".ready"}, 64'(bif.ddr1_ready), 0);
    chk({tag, ".wr_en"}, 64'(bif.bbuf_wr_en), 0);
    chk({tag, ".addr"},  64'(bif.bbuf_wr_addr), 0);
    chk({tag, ".data"},  64'(bif.bbuf_wr_data), 0);
    chk({tag, ".mask"},  64'(bif.bbuf_wr_mask), 0);
  endtask

  // mode: 0 valid steady, 1 valid toggling, 2 valid random. inj: pulse start mid-pass.
  task automatic run_pass(input string tag, input logic [1:0] ty, input int num, input int base,
                          input int mode, input bit inj);
    int pack, w, exp_acc, n0, a0, d0, s, idx, post, nw;
    bit active, acc, v;
    logic [63:0] wd, sl, ed;
    pack    = ty[0] ? 8 : 4;
    w       = ty[0] ? 8 : 16;
    active  = ty[1] && (num > 0);
    exp_acc = active ? (num + pack - 1) / pack : 0;
    n0 = obs_addr.size(); a0 = acc_cyc.size(); d0 = done_cnt;

    @(posedge clk); #1;
    bif.conf_trans_type = ty;
    bif.conf_trans_num  = 8'(num);
    bif.conf_addr_base  = 8'(base);
    bif.start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    bif.start = 1'b0;

    idx = 0; post = 0;
    for (int c = 0; c < 300 && post < 4; c++) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
      bif.ddr1_valid = v && (idx < words.size());
      bif.ddr1_data  = (idx < words.size()) ? words[idx] : 64'd0;
      bif.start      = inj && (c == 3);
      @(negedge clk);
      acc = bif.ddr1_valid && bif.ddr1_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      if (done_cnt > d0) post++;
    end
    bif.ddr1_valid = 1'b0;
    bif.start = 1'b0;

    nw = obs_addr.size() - n0;
    chk({tag, ".done_cnt"}, 64'(done_cnt - d0), 1);
    chk({tag, ".wr_cnt"}, 64'(nw), active ? 64'(num) : 64'd0);
    chk({tag, ".acc_cnt"}, 64'(acc_cyc.size() - a0), 64'(exp_acc));
    for (int i = 0; i < nw && i < num && active; i++) begin
      wd = words[i / pack];
      sl = (wd >> ((i % pack) * w)) & ((64'd1 << w) - 64'd1);
      ed = ty[0] ? sl : (sl << 8);
      chk({tag, ".addr"}, 64'(obs_addr[n0+i]), 64'((base + i) % 256));
      chk({tag, ".data"}, 64'(obs_data[n0+i]), ed);
      chk({tag, ".mask"}, 64'(obs_mask[n0+i]), ty[0] ? 64'd1 : 64'd2);
      if (i > 0 && (mode == 0 || i % pack != 0))
        chk({tag, ".gap"}, 64'(obs_cyc[n0+i] - obs_cyc[n0+i-1]), 1);
    end
    if (active && nw > 0) begin
      chk({tag, ".lat"}, 64'(obs_cyc[n0] - acc_cyc[a0]), 2);
      chk({tag, ".done_at"}, 64'(done_cyc), 64'(obs_cyc[n0+nw-1] + 1));
    end else begin
      chk({tag, ".done_at"}, 64'(done_cyc), 64'(s + 1));
    end
  endtask

  initial begin
    int n0, d0, idx, ty, num;
    rst = 1'b1;
    bif.start = 1'b0;
    bif.conf_trans_type = 2'b00;
    bif.conf_trans_num  = 8'd0;
    bif.conf_addr_base  = 8'd0;
    bif.ddr1_data  = 64'd0;
    bif.ddr1_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("reset");

    // Data pass, two words, steady valid (third word offered must not be taken).
    words.delete();
    words.push_back(64'h0004_0003_0002_0001);
    words.push_back(64'h0008_0007_0006_0005);
    words.push_back(64'hdead_beef_cafe_f00d);
    run_pass("data8", 2'b10, 8, 0, 0, 1'b0);

    // Tail pass, partial word, second word offered but never accepted.
    words.delete();
    words.push_back(64'h0807060504030201);
    words.push_back(64'h1111_2222_3333_4444);
    run_pass("tail5", 2'b11, 5, 16, 0, 1'b0);

    fill_words(4);
    run_pass("toggle6", 2'b10, 6, 100, 1, 1'b0);
    fill_words(3);
    run_pass("wrap", 2'b10, 4, 254, 0, 1'b0);
    fill_words(2);
    run_pass("num0", 2'b10, 0, 5, 0, 1'b0);
    fill_words(2);
    run_pass("noop", 2'b01, 10, 5, 0, 1'b0);
    fill_words(4);
    run_pass("inj", 2'b10, 8, 32, 0, 1'b1);

    // Reset in the middle of a data pass.
    fill_words(3);
    n0 = obs_addr.size(); d0 = done_cnt; idx = 0;
    @(posedge clk); #1;
    bif.conf_trans_type = 2'b10; bif.conf_trans_num = 8'd8; bif.conf_addr_base = 8'd0;
    bif.start = 1'b1;
    @(posedge clk); #1;
    bif.start = 1'b0;
    for (int c = 0; c < 50 && (obs_addr.size() - n0) < 3; c++) begin
      bif.ddr1_valid = 1'b1;
      bif.ddr1_data  = words[idx];
      @(negedge clk);
      if (bif.ddr1_ready) idx++;
    end
    chk("rstmid.writes", 64'(obs_addr.size() - n0), 3);
    @(posedge clk); #1;
    rst = 1'b1;
    bif.ddr1_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("rstmid");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rstmid.no_done", 64'(done_cnt - d0), 0);
    fill_words(2);
    run_pass("after_rst", 2'b10, 4, 0, 0, 1'b0);

    // Randomized passes.
    for (int k = 0; k < 10; k++) begin
      ty  = $urandom_range(0, 3);
      num = $urandom_range(0, 40);
      fill_words(num / 4 + 3);
      run_pass("rand", 2'(ty), num, $urandom_range(0, 255), 2, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
